// File: rtl/bcd_digit_converter.sv
// bcd_digit_converter
//
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
// method, one input bit per clock. Feeds per-digit seven-segment decoders;
// code 4'hF is used to darken a digit (blanked leading zero or overflow).
//
// Handshake: a conversion is accepted on a rising edge where start=1 and
// the FSM is in IDLE. busy is high from the accepting edge until done
// drops. done is a one-cycle pulse that coincides with the update of
// bcd_out/overflow; start seen while a conversion runs is dropped.
//
// Ports:
//   clk         - clock, rising edge active
//   rst         - asynchronous, active-high reset
//   start       - conversion request
//   bin_in      - unsigned value to convert (WIDTH bits)
//   blank_zeros - darken leading zero digits (digit 0 is always shown)
//   busy        - conversion in progress (including the done cycle)
//   done        - one-cycle pulse, bcd_out/overflow freshly updated
//   overflow    - last converted value did not fit in DIGITS digits
//   bcd_out     - DIGITS x 4-bit codes, digit 0 in bits [3:0]

module bcd_digit_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  blank_zeros,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Smallest value that does not fit in DIGITS decimal digits.
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              blank_q, blank_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] cat;
    logic [BW-1:0]       final_bcd;
    logic                lead_zero;

    // Add-3 correction on every digit >= 5, then shift the concatenated
    // {scratch, shift} register left by one. The bit leaving the top of
    // the scratch register is a carry beyond DIGITS and is dropped; the
    // overflow flag computed at capture time covers that case.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        cat = {adj, shift_q} << 1;
    end

    // Leading-zero blanking walks from the most significant digit down and
    // stops at the first nonzero digit; digit 0 is never blanked.
    always_comb begin
        final_bcd = scratch_q;
        lead_zero = blank_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead_zero && (scratch_q[4*i +: 4] == 4'd0)) begin
                final_bcd[4*i +: 4] = 4'hF;
            end else begin
                lead_zero = 1'b0;
            end
        end
        if (ovf_flag_q) begin
            final_bcd = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        blank_d    = blank_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Acceptance depends on state only, so a start held high is
                // accepted in the same cycle the done pulse is visible.
                if (start) begin
                    shift_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                    blank_d    = blank_zeros;
                    ovf_flag_d = (64'(bin_in) >= LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = cat[BW+WIDTH-1:WIDTH];
                shift_d   = cat[WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = final_bcd;
                overflow_d = ovf_flag_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            blank_q    <= 1'b0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= '1;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            blank_q    <= blank_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE) || done_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Testbench for bcd_digit_converter: one instance with default parameters
// (WIDTH=8, DIGITS=3) and one with WIDTH=14, DIGITS=4, sharing clock/reset.
// Expected {overflow, bcd} words are queued when a start is driven and
// popped by a monitor when the matching done pulse appears.

module tb_bcd_digit_converter;

  logic clk = 1'b0;
  logic rst;

  // Instance A: defaults
  logic        start_a;
  logic [7:0]  bin_a;
  logic        blank_a;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;

  // Instance B: WIDTH=14, DIGITS=4
  logic        start_b;
  logic [13:0] bin_b;
  logic        blank_b;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_b;

  logic [12:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;

  bcd_digit_converter dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .blank_zeros(blank_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .bcd_out(bcd_a)
  );

  bcd_digit_converter #(.WIDTH(14), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .blank_zeros(blank_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .bcd_out(bcd_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && done_a) begin
      done_cnt_a++;
      if (exp_a_q.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        chk("a_bcd", 32'(bcd_a), 32'(e[11:0]));
        chk("a_ovf", 32'(ovf_a), 32'(e[12]));
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && done_b) begin
      if (exp_b_q.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        chk("b_bcd", 32'(bcd_b), 32'(e[15:0]));
        chk("b_ovf", 32'(ovf_b), 32'(e[16]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is positioned just after a rising edge with the DUT idle.
  task automatic conv_a(input logic [7:0] v, input logic b, input logic [11:0] e);
    int n;
    int busy_cycles;
    start_a = 1'b1;
    bin_a   = v;
    blank_a = b;
    exp_a_q.push_back({1'b0, e});
    step();                       // accepting edge
    start_a = 1'b0;
    busy_cycles = busy_a ? 1 : 0;
    n = 0;
    while (!done_a && n < 40) begin
      step();
      n++;
      if (busy_a) busy_cycles++;
    end
    chk("a_latency", 32'(n), 32'd9);
    chk("a_busy_cycles", 32'(busy_cycles), 32'd10);
    step();
    chk("a_done_low", 32'(done_a), 32'd0);
    chk("a_busy_low", 32'(busy_a), 32'd0);
  endtask

  task automatic conv_b(input logic [13:0] v, input logic b, input logic ovf, input logic [15:0] e);
    int n;
    start_b = 1'b1;
    bin_b   = v;
    blank_b = b;
    exp_b_q.push_back({ovf, e});
    step();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 60) begin
      step();
      n++;
    end
    chk("b_latency", 32'(n), 32'd15);
    step();
    chk("b_busy_low", 32'(busy_b), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int seen;
    int base;
    rst = 1'b1;
    start_a = 1'b0; bin_a = '0; blank_a = 1'b0;
    start_b = 1'b0; bin_b = '0; blank_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd_a", 32'(bcd_a), 32'hFFF);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_bcd_b", 32'(bcd_b), 32'hFFFF);
    rst = 1'b0;
    step();

    // Main function, instance A
    conv_a(8'd255, 1'b0, 12'h255);
    conv_a(8'd7,   1'b1, 12'hFF7);
    conv_a(8'd0,   1'b1, 12'hFF0);
    conv_a(8'd0,   1'b0, 12'h000);
    conv_a(8'd100, 1'b1, 12'h100);
    conv_a(8'd90,  1'b1, 12'hF90);
    conv_a(8'd9,   1'b0, 12'h009);
    n = $urandom_range(255, 0);
    conv_a(8'(n), 1'b0, {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)});

    // Instance B: overflow boundary and blanking
    conv_b(14'd9999,  1'b0, 1'b0, 16'h9999);
    conv_b(14'd12000, 1'b0, 1'b1, 16'hFFFF);
    conv_b(14'd10000, 1'b1, 1'b1, 16'hFFFF);
    conv_b(14'd1024,  1'b1, 1'b0, 16'h1024);
    conv_b(14'd5,     1'b1, 1'b0, 16'hFFF5);
    chk("b_ovf_held", 32'(ovf_b), 32'd0);

    // start while busy is ignored; bin_in changes after capture have no effect
    seen = done_cnt_a;
    start_a = 1'b1; bin_a = 8'd123; blank_a = 1'b0;
    exp_a_q.push_back({1'b0, 12'h123});
    step();
    start_a = 1'b0; bin_a = 8'd77; blank_a = 1'b1;
    repeat (2) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (25) step();
    chk("ignored_start_dones", 32'(done_cnt_a - seen), 32'd1);
    chk("ignored_start_busy", 32'(busy_a), 32'd0);

    // start held high: one done every 10 cycles
    seen = 0;
    base = 0;
    exp_a_q.push_back({1'b0, 12'h042});
    exp_a_q.push_back({1'b0, 12'h042});
    exp_a_q.push_back({1'b0, 12'h042});
    start_a = 1'b1; bin_a = 8'd42; blank_a = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done_a) begin
        seen++;
        chk("held_done_spacing", 32'(i - base), 32'(seen == 1 ? 10 : 10));
        base = i;
      end
    end
    start_a = 1'b0;
    chk("held_done_count", 32'(seen), 32'd3);
    step();
    chk("held_idle", 32'(busy_a), 32'd0);

    // Reset mid-conversion: immediate async clear, no done for 200
    seen = done_cnt_a;
    start_a = 1'b1; bin_a = 8'd200;
    step();
    start_a = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bcd", 32'(bcd_a), 32'hFFF);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_done", 32'(done_a), 32'd0);
    chk("async_rst_ovf", 32'(ovf_a), 32'd0);
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("no_done_after_abort", 32'(done_cnt_a - seen), 32'd0);
    chk("bcd_dark_after_abort", 32'(bcd_a), 32'hFFF);

    start_a = 1'b1; bin_a = 8'd13; blank_a = 1'b0;
    exp_a_q.push_back({1'b0, 12'h013});
    step();
    start_a = 1'b0;
    repeat (8) step();
    chk("bcd_dark_before_done", 32'(bcd_a), 32'hFFF);
    chk("done_not_yet", 32'(done_a), 32'd0);
    n = 0;
    while (!done_a && n < 10) begin
      step();
      n++;
    end
    chk("post_rst_latency", 32'(n), 32'd1);
    repeat (3) step();
    chk("post_rst_bcd_held", 32'(bcd_a), 32'h013);

    chk("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
